// File: rtl/rtx_scheduler.sv
// Frame scheduler for a pool of ray-tracer lanes: issues pixel coordinates in
// raster order to free lanes and collects their results round-robin.
module rtx_scheduler #(
  parameter int WIDTH   = 1280,
  parameter int HEIGHT  = 720,
  parameter int N_LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  output logic [N_LANES-1:0]     lane_start,
  output logic [10:0]            lane_pixel_h,
  output logic [9:0]             lane_pixel_v,
  input  logic [N_LANES-1:0]     lane_done,
  input  logic [16*N_LANES-1:0]  lane_pixel,
  input  logic [11*N_LANES-1:0]  lane_h_in,
  input  logic [10*N_LANES-1:0]  lane_v_in,
  output logic [N_LANES-1:0]     lane_ack,
  output logic [15:0]            rtx_pixel,
  output logic [10:0]            pixel_h,
  output logic [9:0]             pixel_v,
  output logic                   pixel_valid,
  output logic                   frame_done,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int         PW     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

  state_t               state_q, state_d;
  logic [N_LANES-1:0]   busy_mask_q, busy_mask_d;
  logic [PW-1:0]        p_q, p_d;
  logic [10:0]          h_q, h_d;
  logic [9:0]           v_q, v_d;
  logic [15:0]          rtx_pixel_q, rtx_pixel_d;
  logic [10:0]          pixel_h_q, pixel_h_d;
  logic [9:0]           pixel_v_q, pixel_v_d;
  logic                 pixel_valid_q, pixel_valid_d;
  logic                 frame_done_q, frame_done_d;

  logic                 issue_en, collect_en, issue;
  logic [N_LANES-1:0]   issue_sel, ack_sel, req;
  int                   idx;

  assign issue_en   = !rst && (state_q == S_RUN);
  assign collect_en = !rst && (state_q == S_RUN || state_q == S_DRAIN);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    issue_sel = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (issue_en && !busy_mask_q[i] && issue_sel == '0) issue_sel[i] = 1'b1;
    end
  end

  assign issue = |issue_sel;

  // Only lanes we actually issued to may be acked; stale done levels are ignored.
  assign req = lane_done & busy_mask_q & {N_LANES{collect_en}};

  always_comb begin
    ack_sel = '0;
    p_d     = p_q;
    idx     = 0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = int'(p_q) + i;
      if (idx >= N_LANES) idx = idx - N_LANES;
      if (ack_sel == '0 && req[PW'(idx)]) begin
        ack_sel[PW'(idx)] = 1'b1;
        p_d = (idx == N_LANES - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_comb begin
    rtx_pixel_d   = rtx_pixel_q;
    pixel_h_d     = pixel_h_q;
    pixel_v_d     = pixel_v_q;
    pixel_valid_d = |ack_sel;
    for (int i = 0; i < N_LANES; i++) begin
      if (ack_sel[i]) begin
        rtx_pixel_d = lane_pixel[16*i +: 16];
        pixel_h_d   = lane_h_in[11*i +: 11];
        pixel_v_d   = lane_v_in[10*i +: 10];
      end
    end
  end

  assign busy_mask_d = (busy_mask_q | issue_sel) & ~ack_sel;

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          h_d     = '0;
          v_d     = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              v_d     = '0;
              state_d = S_DRAIN;
            end else begin
              v_d = v_q + 10'd1;
            end
          end else begin
            h_d = h_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        if (busy_mask_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = continuous ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_mask_q   <= '0;
      p_q           <= '0;
      h_q           <= '0;
      v_q           <= '0;
      rtx_pixel_q   <= '0;
      pixel_h_q     <= '0;
      pixel_v_q     <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_mask_q   <= busy_mask_d;
      p_q           <= p_d;
      h_q           <= h_d;
      v_q           <= v_d;
      rtx_pixel_q   <= rtx_pixel_d;
      pixel_h_q     <= pixel_h_d;
      pixel_v_q     <= pixel_v_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign lane_start   = issue_sel;
  assign lane_ack     = ack_sel;
  assign lane_pixel_h = h_q;
  assign lane_pixel_v = v_q;
  assign rtx_pixel    = rtx_pixel_q;
  assign pixel_h      = pixel_h_q;
  assign pixel_v      = pixel_v_q;
  assign pixel_valid  = pixel_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtx_scheduler.sv
// Directed bench for rtx_scheduler on a 4x2 frame with 4 lanes: fill order,
// round-robin collection, full frames with a lane model, and reset robustness.
module tb_rtx_scheduler;
  localparam int NL = 4;
  localparam int W  = 4;
  localparam int H  = 2;

  logic              clk = 1'b0;
  logic              rst, start, continuous;
  logic [NL-1:0]     lane_start, lane_done, lane_ack;
  logic [10:0]       lane_pixel_h, pixel_h;
  logic [9:0]        lane_pixel_v, pixel_v;
  logic [16*NL-1:0]  lane_pixel;
  logic [11*NL-1:0]  lane_h_in;
  logic [10*NL-1:0]  lane_v_in;
  logic [15:0]       rtx_pixel;
  logic              pixel_valid, frame_done, busy;

  int errors = 0;
  int checks = 0;

  rtx_scheduler #(.WIDTH(W), .HEIGHT(H), .N_LANES(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .lane_start(lane_start), .lane_pixel_h(lane_pixel_h), .lane_pixel_v(lane_pixel_v),
    .lane_done(lane_done), .lane_pixel(lane_pixel), .lane_h_in(lane_h_in),
    .lane_v_in(lane_v_in), .lane_ack(lane_ack), .rtx_pixel(rtx_pixel),
    .pixel_h(pixel_h), .pixel_v(pixel_v), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [15:0] px, input logic [10:0] h, input logic [9:0] v);
    lane_pixel[16*i +: 16] = px;
    lane_h_in[11*i +: 11]  = h;
    lane_v_in[10*i +: 10]  = v;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; start = 1'b0; lane_done = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_issue(input string name, input logic [NL-1:0] ls, input int h, input int v);
    checks++;
    if (lane_start !== ls || (ls != '0 && (lane_pixel_h !== 11'(h) || lane_pixel_v !== 10'(v))))
      $display("FAIL %s: lane_start=%b h=%0d v=%0d, expected lane_start=%b h=%0d v=%0d",
               name, lane_start, lane_pixel_h, lane_pixel_v, ls, h, v);
    if (lane_start !== ls || (ls != '0 && (lane_pixel_h !== 11'(h) || lane_pixel_v !== 10'(v))))
      errors++;
  endtask

  task automatic check_out(input string name, input logic [NL-1:0] ack, input logic vld,
                           input logic [15:0] px, input int h, input int v);
    checks++;
    if (lane_ack !== ack || pixel_valid !== vld ||
        (vld && (rtx_pixel !== px || pixel_h !== 11'(h) || pixel_v !== 10'(v)))) begin
      errors++;
      $display("FAIL %s: ack=%b valid=%b pix=%h h=%0d v=%0d, expected ack=%b valid=%b pix=%h h=%0d v=%0d",
               name, lane_ack, pixel_valid, rtx_pixel, pixel_h, pixel_v, ack, vld, px, h, v);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({lane_start, lane_ack, rtx_pixel, pixel_h, pixel_v, pixel_valid, frame_done, busy,
         lane_pixel_h, lane_pixel_v} !== '0) begin
      errors++;
      $display("FAIL %s: start=%b ack=%b pix=%h h=%0d v=%0d valid=%b fd=%b busy=%b lh=%0d lv=%0d, expected all zero",
               name, lane_start, lane_ack, rtx_pixel, pixel_h, pixel_v, pixel_valid, frame_done,
               busy, lane_pixel_h, lane_pixel_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; continuous = 1'b0; lane_done = '0;
    lane_pixel = '0; lane_h_in = '0; lane_v_in = '0;
    next_cycle();
    next_cycle();
    #1;
    check_all_zero("reset_held");
    next_cycle();
    rst = 1'b0;
    #1;
    check_all_zero("reset_released");
  endtask

  task automatic test_fill();
    next_cycle();
    start = 1'b1;
    #1;
    check_issue("fill_idle", 4'b0000, 0, 0);
    next_cycle();
    start = 1'b0;
    #1;
    check_issue("fill_lane0", 4'b0001, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_busy: busy=%b, expected 1", busy);
    end
    for (int k = 1; k < NL; k++) begin
      next_cycle();
      #1;
      check_issue($sformatf("fill_lane%0d", k), NL'(1 << k), k, 0);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      check_issue("fill_stall", 4'b0000, 0, 0);
    end
  endtask

  // Entered with all lanes busy, next coordinate (0,1) and pointer 0.
  task automatic test_arbitration();
    next_cycle();
    lane_done = 4'b1010;
    set_lane(1, 16'h1111, 11'd5, 10'd6);
    set_lane(3, 16'h3333, 11'd7, 10'd8);
    #1;
    check_out("arb_grant_lane1", 4'b0010, 1'b0, 16'h0, 0, 0);
    next_cycle();
    lane_done = 4'b1000;
    #1;
    check_out("arb_grant_lane3", 4'b1000, 1'b1, 16'h1111, 5, 6);
    check_issue("arb_reissue_lane1", 4'b0010, 0, 1);
    next_cycle();
    lane_done = 4'b0000;
    #1;
    check_out("arb_out_lane3", 4'b0000, 1'b1, 16'h3333, 7, 8);
    check_issue("arb_reissue_lane3", 4'b1000, 1, 1);
    next_cycle();
    lane_done = 4'b1001;
    set_lane(0, 16'h0A0A, 11'd1, 10'd2);
    set_lane(3, 16'h0B0B, 11'd3, 10'd4);
    #1;
    check_out("arb_ptr_wrap_lane0", 4'b0001, 1'b0, 16'h0, 0, 0);
    next_cycle();
    lane_done = 4'b1000;
    #1;
    check_out("arb_second_lane3", 4'b1000, 1'b1, 16'h0A0A, 1, 2);
    next_cycle();
    lane_done = 4'b0000;
    #1;
    check_out("arb_out_b", 4'b0000, 1'b1, 16'h0B0B, 3, 4);
    next_cycle();
    #1;
    check_out("arb_hold_data", 4'b0000, 1'b0, 16'h0, 0, 0);
    checks++;
    if (rtx_pixel !== 16'h0B0B || pixel_h !== 11'd3 || pixel_v !== 10'd4) begin
      errors++;
      $display("FAIL arb_hold_value: pix=%h h=%0d v=%0d, expected pix=0b0b h=3 v=4",
               rtx_pixel, pixel_h, pixel_v);
    end
    do_reset();
  endtask

  task automatic test_idle_done();
    next_cycle();
    lane_done = 4'b1111;
    for (int i = 0; i < NL; i++) set_lane(i, 16'hDEAD, 11'd9, 10'd9);
    #1;
    check_out("idle_done_no_ack", 4'b0000, 1'b0, 16'h0, 0, 0);
    next_cycle();
    #1;
    check_out("idle_done_no_out", 4'b0000, 1'b0, 16'h0, 0, 0);
    lane_done = '0;
  endtask

  task automatic test_start_in_run_and_reset();
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    #1;
    check_issue("run_issue0", 4'b0001, 0, 0);
    next_cycle();
    start = 1'b1;
    #1;
    check_issue("run_start_ignored", 4'b0010, 1, 0);
    next_cycle();
    start = 1'b0;
    #1;
    check_issue("run_issue2", 4'b0100, 2, 0);
    next_cycle();
    rst = 1'b1;
    start = 1'b1;
    next_cycle();
    rst = 1'b0;
    start = 1'b0;
    lane_done = 4'b0111;
    #1;
    check_all_zero("midframe_reset");
    next_cycle();
    lane_done = '0;
    #1;
    check_out("late_done_ignored", 4'b0000, 1'b0, 16'h0, 0, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_full_frame(input logic cont);
    int          due [NL];
    int          seen [W*H];
    int          n_valid, n_fd, n_iss, fd_cyc, bad, k;
    logic        exp_valid, finished;
    logic [15:0] exp_px;
    logic [10:0] exp_h;
    logic [9:0]  exp_v;
    logic [NL-1:0] prev_ack;
    for (int i = 0; i < NL; i++) due[i] = -1;
    for (int i = 0; i < W*H; i++) seen[i] = 0;
    n_valid = 0; n_fd = 0; n_iss = 0; fd_cyc = -1; bad = 0; finished = 1'b0;
    exp_valid = 1'b0; exp_px = '0; exp_h = '0; exp_v = '0; prev_ack = '0;
    continuous = cont;
    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      next_cycle();
      start = (cyc == 0);
      for (int i = 0; i < NL; i++) begin
        if (prev_ack[i]) lane_done[i] = 1'b0;
        if (due[i] == cyc) lane_done[i] = 1'b1;
      end
      #1;
      for (int i = 0; i < NL; i++) begin
        if (lane_start[i]) begin
          due[i] = cyc + 5;
          set_lane(i, {lane_pixel_h[7:0], lane_pixel_v[7:0]}, lane_pixel_h, lane_pixel_v);
        end
      end
      if (lane_start != '0) begin
        checks++;
        if (lane_pixel_h !== 11'(n_iss % W) || lane_pixel_v !== 10'((n_iss % (W*H)) / W)) begin
          errors++;
          $display("FAIL frame_issue_order: issue %0d at h=%0d v=%0d, expected h=%0d v=%0d",
                   n_iss, lane_pixel_h, lane_pixel_v, n_iss % W, (n_iss % (W*H)) / W);
        end
        n_iss++;
      end
      checks++;
      if (pixel_valid !== exp_valid ||
          (exp_valid && (rtx_pixel !== exp_px || pixel_h !== exp_h || pixel_v !== exp_v))) begin
        errors++;
        $display("FAIL frame_output cyc=%0d: valid=%b pix=%h h=%0d v=%0d, expected valid=%b pix=%h h=%0d v=%0d",
                 cyc, pixel_valid, rtx_pixel, pixel_h, pixel_v, exp_valid, exp_px, exp_h, exp_v);
      end
      if (pixel_valid) begin
        n_valid++;
        k = int'(pixel_v) * W + int'(pixel_h);
        if (k >= 0 && k < W*H) seen[k]++;
        else bad++;
      end
      checks++;
      if ((lane_ack & ~lane_done) != '0 || $countones(lane_ack) > 1) begin
        errors++;
        $display("FAIL frame_ack_legal cyc=%0d: ack=%b done=%b, expected one-hot subset of done",
                 cyc, lane_ack, lane_done);
      end
      exp_valid = |lane_ack;
      for (int i = 0; i < NL; i++) begin
        if (lane_ack[i]) begin
          exp_px = lane_pixel[16*i +: 16];
          exp_h  = lane_h_in[11*i +: 11];
          exp_v  = lane_v_in[10*i +: 10];
        end
      end
      prev_ack = lane_ack;
      if (frame_done) begin
        n_fd++;
        fd_cyc = cyc;
        if (cont) begin
          check_issue("cont_restart", 4'b0001, 0, 0);
          finished = 1'b1;
        end
      end
      if (!cont && fd_cyc >= 0 && cyc == fd_cyc + 3) finished = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL frame_timeout: frame_done count=%0d, expected frame end within 80 cycles", n_fd);
    end
    checks++;
    if (n_valid != W*H || n_fd != 1 || bad != 0) begin
      errors++;
      $display("FAIL frame_counts: pixels=%0d frame_done=%0d bad=%0d, expected pixels=%0d frame_done=1 bad=0",
               n_valid, n_fd, bad, W*H);
    end
    for (int i = 0; i < W*H; i++) begin
      checks++;
      if (seen[i] != 1) begin
        errors++;
        $display("FAIL frame_coverage: (h=%0d,v=%0d) seen %0d times, expected 1", i % W, i / W, seen[i]);
      end
    end
    if (!cont) begin
      checks++;
      if (busy !== 1'b0 || lane_start !== '0) begin
        errors++;
        $display("FAIL frame_idle: busy=%b lane_start=%b, expected busy=0 lane_start=0000", busy, lane_start);
      end
    end
    continuous = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_arbitration();
    test_idle_done();
    test_start_in_run_and_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
